hdr_cmd_sequencer: RTL
======================

Name: hdr_cmd_sequencer

Overview:
- Next-generation HDR engine controller that sits between the I3C main engine and the HDR sub-blocks (CCC block, HDR-DDR transfer block, restart/exit pattern generator).
- Accepts a stream of HDR commands through a valid/ready handshake and dispatches each one to the CCC or normal-transfer block.
- Handles TOC-driven HDR Restart vs HDR Exit, a per-command watchdog timeout, and abort on engine disable.
- Returns one response (TID, error status, data length) per command, and signals the main engine only after HDR Exit completes.

Parameters:
MODE_W, 3, width of the mode field
HDR_MODE, 6, mode code accepted as HDR-DDR; any other code is rejected
TID_W, 4, transaction ID width
DLEN_W, 16, data length width
TMO_W, 16, watchdog counter width
TMO_CYCLES, 16'd4096, cycles allowed in CCC/XFER before timeout; 0 disables the watchdog

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  synchronous, active-high reset
i_i3cengine_hdrengine_en  in  1  engine enable from the I3C main engine
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  command accepted when high together with i_cmd_valid
i_cmd_cp  in  1  1 = CCC command, 0 = normal transfer
i_cmd_toc  in  1  1 = exit after this command, 0 = restart
i_cmd_mode  in  MODE_W  requested mode
i_cmd_tid  in  TID_W  transaction ID
i_cmd_dlen  in  DLEN_W  data length
i_ccc_done  in  1  CCC block finished (1-cycle pulse)
i_hdr_mode_done  in  1  transfer block finished (1-cycle pulse)
i_pattern_done  in  1  restart/exit pattern finished (1-cycle pulse)
o_ccc_en  out  1  CCC block enable (level)
o_hdrmode_en  out  1  transfer block enable (level)
o_restart_en  out  1  HDR Restart pattern request (level)
o_exit_en  out  1  HDR Exit pattern request (level)
o_in_hdr  out  1  bus is in HDR mode (between the first accepted command and Exit completion)
o_resp_valid  out  1  response valid
i_resp_ready  in  1  response consumed
o_resp_tid  out  TID_W  echoed TID
o_resp_err  out  8  error status: 0x00 ok, 0x01 bad mode, 0x02 timeout, 0x04 abort
o_resp_dlen  out  DLEN_W  echoed data length
o_i3cengine_hdrengine_done  out  1  1-cycle pulse after Exit completes and its response is taken

Behaviour:
Reset and output timing
- On i_sys_rst, all outputs go to 0, the state goes to IDLE, and the latched fields and the watchdog are cleared.
- All outputs are registered. Reset takes priority over every other event.

States: IDLE, CCC, XFER, RESTART, EXIT, RESP.

IDLE
- o_cmd_ready = i_i3cengine_hdrengine_en.
- On accept (valid && ready), latch cp/toc/mode/tid/dlen and clear the watchdog.
- If mode != HDR_MODE: set err=0x01, set the exit flag = o_in_hdr, go to EXIT if o_in_hdr, else RESP. No block enables are raised.
- Else: set o_in_hdr=1 and go to CCC if cp, else XFER.
- The first enable is asserted in the cycle after accept (1-cycle latency).

CCC / XFER
- Hold o_ccc_en / o_hdrmode_en high. The watchdog increments each cycle.
- On the matching done pulse, drop the enable next cycle and go to EXIT if toc, else RESTART.
- Watchdog reaching TMO_CYCLES-1 (TMO_CYCLES != 0): set err=0x02 and go to EXIT.
- Done and timeout in the same cycle: done wins, err stays 0x00.
- i_i3cengine_hdrengine_en low: set err=0x04 and go to EXIT. Abort takes priority over timeout but not over done.
- The non-matching done input is ignored.

RESTART
- Hold o_restart_en until i_pattern_done, then go to RESP.
- o_in_hdr stays 1.

EXIT
- Hold o_exit_en until i_pattern_done, then clear o_in_hdr, set the exit flag, and go to RESP.

RESP
- Hold o_resp_valid with the latched tid/dlen/err, stable until i_resp_ready.
- On handshake: return to IDLE. If the exit flag is set, pulse o_i3cengine_hdrengine_done for exactly 1 cycle, then clear the flag.

Invariants
- At most one of o_ccc_en, o_hdrmode_en, o_restart_en, o_exit_en is high in any cycle.
- o_cmd_ready is 0 outside IDLE.
- Done pulses arriving in an unrelated state are ignored.

Test Plan:
1. CCC with exit: cp=1, toc=1, mode=6, tid=3, dlen=8; i_ccc_done pulse after 5 cycles; i_pattern_done 4 cycles after o_exit_en rises -> o_ccc_en high for 5 cycles, then o_exit_en, then response tid=3/err=0x00/dlen=8, then done pulse 1 cycle; o_in_hdr ends 0.
2. Restart chaining: xfer with toc=0 (tid=1), then xfer with toc=1 (tid=2) -> o_restart_en between the two commands, o_in_hdr stays 1 throughout, two responses with err=0x00, single done pulse after the second.
3. Bad mode: mode=2 from IDLE with o_in_hdr=0 -> no enables raised, response err=0x01, no done pulse. The same while in HDR -> exit pattern, response err=0x01, done pulse.
4. Timeout: TMO_CYCLES=16, i_hdr_mode_done never arrives -> o_hdrmode_en high for exactly 16 cycles, then exit, err=0x02. Done and timeout in the same cycle -> err=0x00.
5. Abort: drop i_i3cengine_hdrengine_en mid-CCC -> exit, err=0x04, done pulse. Assert i_sys_rst mid-XFER -> all outputs 0 the next cycle, state IDLE.
6. Backpressure: hold i_resp_ready=0 for 10 cycles -> o_resp_valid and its fields stable, o_cmd_ready=0, no new command accepted.

Source files
------------

// File: rtl/hdr_cmd_sequencer.sv
// HDR engine command sequencer: accepts HDR commands, dispatches them to the CCC or
// HDR-DDR transfer block, then runs the restart or exit pattern and returns one response per command.
module hdr_cmd_sequencer #(
    parameter int                 MODE_W     = 3,
    parameter int unsigned        HDR_MODE   = 6,
    parameter int                 TID_W      = 4,
    parameter int                 DLEN_W     = 16,
    parameter int                 TMO_W      = 16,
    parameter logic [TMO_W-1:0]   TMO_CYCLES = 16'd4096
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_i3cengine_hdrengine_en,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_cp,
    input  logic              i_cmd_toc,
    input  logic [MODE_W-1:0] i_cmd_mode,
    input  logic [TID_W-1:0]  i_cmd_tid,
    input  logic [DLEN_W-1:0] i_cmd_dlen,
    input  logic              i_ccc_done,
    input  logic              i_hdr_mode_done,
    input  logic              i_pattern_done,
    output logic              o_ccc_en,
    output logic              o_hdrmode_en,
    output logic              o_restart_en,
    output logic              o_exit_en,
    output logic              o_in_hdr,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [TID_W-1:0]  o_resp_tid,
    output logic [7:0]        o_resp_err,
    output logic [DLEN_W-1:0] o_resp_dlen,
    output logic              o_i3cengine_hdrengine_done
);

    localparam logic [MODE_W-1:0] L_HDR_MODE = MODE_W'(HDR_MODE);
    localparam logic [TMO_W-1:0]  L_TMO_LAST = TMO_CYCLES - TMO_W'(1);
    localparam logic [7:0]        ERR_OK    = 8'h00;
    localparam logic [7:0]        ERR_MODE  = 8'h01;
    localparam logic [7:0]        ERR_TMO   = 8'h02;
    localparam logic [7:0]        ERR_ABORT = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CCC,
        S_XFER,
        S_RESTART,
        S_EXIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_ccc_en;
    logic                r_hdrmode_en;
    logic                r_restart_en;
    logic                r_exit_en;
    logic                r_in_hdr;
    logic                r_resp_valid;
    logic [TID_W-1:0]    r_resp_tid;
    logic [7:0]          r_resp_err;
    logic [DLEN_W-1:0]   r_resp_dlen;
    logic                r_done;
    logic                r_toc;
    logic                r_exit_flag;
    logic [TMO_W-1:0]    r_wdog;

    logic w_accept;
    logic w_bad_mode;
    logic w_blk_done;
    logic w_tmo_hit;

    assign w_accept   = i_cmd_valid && r_cmd_ready;
    assign w_bad_mode = (i_cmd_mode != L_HDR_MODE);
    // Only the done pulse of the block currently enabled counts; the other is ignored.
    assign w_blk_done = (r_state == S_CCC) ? i_ccc_done : i_hdr_mode_done;
    assign w_tmo_hit  = (TMO_CYCLES != '0) && (r_wdog == L_TMO_LAST);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_ccc_en     <= 1'b0;
            r_hdrmode_en <= 1'b0;
            r_restart_en <= 1'b0;
            r_exit_en    <= 1'b0;
            r_in_hdr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_tid   <= '0;
            r_resp_err   <= ERR_OK;
            r_resp_dlen  <= '0;
            r_done       <= 1'b0;
            r_toc        <= 1'b0;
            r_exit_flag  <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= i_i3cengine_hdrengine_en;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_toc       <= i_cmd_toc;
                        r_resp_tid  <= i_cmd_tid;
                        r_resp_dlen <= i_cmd_dlen;
                        r_wdog      <= '0;
                        if (w_bad_mode) begin
                            // A rejected command still has to leave HDR cleanly if the bus is in it.
                            r_resp_err  <= ERR_MODE;
                            r_exit_flag <= r_in_hdr;
                            if (r_in_hdr) begin
                                r_state   <= S_EXIT;
                                r_exit_en <= 1'b1;
                            end else begin
                                r_state      <= S_RESP;
                                r_resp_valid <= 1'b1;
                            end
                        end else begin
                            r_resp_err <= ERR_OK;
                            r_in_hdr   <= 1'b1;
                            if (i_cmd_cp) begin
                                r_state  <= S_CCC;
                                r_ccc_en <= 1'b1;
                            end else begin
                                r_state      <= S_XFER;
                                r_hdrmode_en <= 1'b1;
                            end
                        end
                    end
                end

                S_CCC, S_XFER: begin
                    r_wdog <= r_wdog + TMO_W'(1);
                    // Priority: done, then abort, then timeout.
                    if (w_blk_done) begin
                        r_ccc_en     <= 1'b0;
                        r_hdrmode_en <= 1'b0;
                        if (r_toc) begin
                            r_state   <= S_EXIT;
                            r_exit_en <= 1'b1;
                        end else begin
                            r_state      <= S_RESTART;
                            r_restart_en <= 1'b1;
                        end
                    end else if (!i_i3cengine_hdrengine_en) begin
                        r_ccc_en     <= 1'b0;
                        r_hdrmode_en <= 1'b0;
                        r_resp_err   <= ERR_ABORT;
                        r_state      <= S_EXIT;
                        r_exit_en    <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_ccc_en     <= 1'b0;
                        r_hdrmode_en <= 1'b0;
                        r_resp_err   <= ERR_TMO;
                        r_state      <= S_EXIT;
                        r_exit_en    <= 1'b1;
                    end
                end

                S_RESTART: begin
                    if (i_pattern_done) begin
                        r_restart_en <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end

                S_EXIT: begin
                    if (i_pattern_done) begin
                        r_exit_en    <= 1'b0;
                        r_in_hdr     <= 1'b0;
                        r_exit_flag  <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (i_resp_ready) begin
                        // The main engine is told only once the exit's response has been taken.
                        r_resp_valid <= 1'b0;
                        r_done       <= r_exit_flag;
                        r_exit_flag  <= 1'b0;
                        r_cmd_ready  <= i_i3cengine_hdrengine_en;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready                = r_cmd_ready;
    assign o_ccc_en                   = r_ccc_en;
    assign o_hdrmode_en               = r_hdrmode_en;
    assign o_restart_en               = r_restart_en;
    assign o_exit_en                  = r_exit_en;
    assign o_in_hdr                   = r_in_hdr;
    assign o_resp_valid               = r_resp_valid;
    assign o_resp_tid                 = r_resp_tid;
    assign o_resp_err                 = r_resp_err;
    assign o_resp_dlen                = r_resp_dlen;
    assign o_i3cengine_hdrengine_done = r_done;

endmodule
